eth_rx_frame_check: RTL and testbench
=====================================

// Module: eth_rx_frame_check
// PURPOSE
// Receive-side counterpart of eth_tx: consumes the raw RMII dibit stream (preamble, SFD, body, FCS)
// and locates the SFD. Emits frame bytes (dst MAC through payload, FCS stripped) and checks the CRC-32 residue.
// Also checks alignment and length, then reports per-frame status. Feeds eth_rx-style consumers upstream of
// the dibit PHY interface.
// PARAMETERS
// MIN_PREAMBLE_DIBITS  4     consecutive 2'b01 dibits required before SFD dibit 2'b11
// MIN_FRAME_LEN        64    min bytes dst MAC..FCS inclusive; shorter -> err
// MAX_FRAME_LEN        1518  max bytes dst MAC..FCS inclusive; longer -> err, rest of frame dropped
// PORTS
// clk        in   1   system clock, one dibit per cycle max
// rst_n      in   1   asynchronous active-low reset
// inclk      in   1   dibit valid (qualified CRS_DV); low cycle ends a frame
// in         in   2   dibit, LSB-first within byte
// my_mac     in   48  station MAC, byte 0 in [0+:8] (used only with filter)
// outclk     out  1   out valid strobe, one byte
// out        out  8   frame byte, dst MAC first, FCS never emitted
// done       out  1   1-cycle pulse: frame finished, status valid
// err        out  1   valid with done: CRC/alignment/length failure
// filtered   out  1   valid with done: frame rejected by MAC filter
// BEHAVIOUR
// - Reset: state=IDLE, outclk/done/err/filtered=0, out=0, queue empty, counters 0; reset mid-frame discards all.
// - States: IDLE, PREAMBLE, BODY, DROP.
//   IDLE: inclk&&in==01 -> PREAMBLE, pcnt=1.
//   PREAMBLE: in==01 -> pcnt++ (saturating); in==11&&pcnt>=MIN_PREAMBLE_DIBITS -> BODY, CRC=32'hffffffff;
//     any other dibit, or inclk low -> IDLE (silent, no done).
//   BODY: each dibit feeds CRC (reflected poly 32'hedb88320, 2 bits/cycle) and byte assembler;
//     4th dibit completes byte {d3,d2,d1,d0} -> push to holdback queue, bcnt++ (11-bit).
//     bcnt reaching MAX_FRAME_LEN+1 -> DROP (err latched).
//   DROP: ignore dibits until inclk low; no further pushes or outclk.
// - Holdback queue: 8 bytes. Emit one byte per cycle (outclk) while depth>4 and emission enabled.
//   Byte rate is <=1 per 4 cycles, so the queue never overflows. The last 4 bytes (FCS) remain and are discarded.
// - End of frame (inclk low while in BODY/DROP): next cycle done=1 for exactly 1 cycle.
//   err=1 if any of: dibit count mod 4 != 0; bcnt<MIN_FRAME_LEN; CRC register != 32'hDEBB20E3; DROP due to length.
//   Queue is flushed; state -> IDLE.
//   Bytes still queued beyond depth 4 at end (runt) are discarded; no outclk after done.
// - inclk high with in==01 on the cycle done pulses starts a new PREAMBLE normally.
// - Latency: byte k's outclk occurs 1 cycle after byte k+4 completes (1 cycle after push when depth>4).
// CONFIGURATION
// ETH_RX_MAC_FILTER_EN defined:
//   - Emission is disabled until dst MAC (bytes 0..5) is complete.
//   - Match my_mac or ff:ff:ff:ff:ff:ff -> enable; the 2 extra queued bytes drain on the next 2 cycles.
//   - Mismatch -> DROP: no outclk for frame; done pulses with filtered=1, err from normal checks.
// ETH_RX_MAC_FILTER_EN undefined:
//   - Emission is enabled from the first byte; my_mac is ignored; filtered is tied 0.
// TESTING
// 1. 64-byte frame (60 body + valid FCS), 28 dibits 01 + 11 preamble -> 60 outclk bytes match, done err=0.
// 2. Same frame, one payload bit flipped -> 60 outclk, done err=1.
// 3. Frame truncated by one dibit -> done err=1 (misaligned); 40-byte frame with valid FCS -> err=1 (runt).
// 4. Only 3 dibits 01 then 11, then body -> no outclk, no done; followed by a good frame -> normal receive.
// 5. FILTER_EN, dst=02:00:00:00:00:01 vs my_mac=02:00:00:00:00:02 -> 0 outclk, done filtered=1.
//    Broadcast dst -> 60 outclk, filtered=0.
// 6. rst_n low mid-body for 1 cycle -> all outputs 0 immediately, no done; next good frame -> err=0.

Source files
------------

// File: rtl/eth_rx_frame_check.sv
// RMII receive framer: finds the SFD, emits frame bytes with the FCS held back, and checks CRC/alignment/length.
// Define ETH_RX_MAC_FILTER_EN to accept only frames addressed to my_mac or broadcast.
module eth_rx_frame_check #(
  parameter int MIN_PREAMBLE_DIBITS = 4,
  parameter int MIN_FRAME_LEN       = 64,
  parameter int MAX_FRAME_LEN       = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inclk,
  input  logic [1:0]  in,
  input  logic [47:0] my_mac,
  output logic        outclk,
  output logic [7:0]  out,
  output logic        done,
  output logic        err,
  output logic        filtered
);
  localparam int          PW      = $clog2(MIN_PREAMBLE_DIBITS + 2);
  localparam logic [PW-1:0] PMIN  = PW'(MIN_PREAMBLE_DIBITS);
  localparam logic [10:0] MINL    = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAXL    = 11'(MAX_FRAME_LEN);
  localparam logic [31:0] POLY    = 32'hedb88320;
  localparam logic [31:0] RESIDUE = 32'hdebb20e3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [31:0]     crc, crc_n;
  logic [1:0]      dcnt;
  logic [5:0]      shreg;
  logic [10:0]     bcnt;
  logic [7:0][7:0] q, q_n;
  logic [3:0]      depth, depth_n;
  logic [7:0]      byte_in;
  logic            len_err, emit_en, mac_rej;
  logic            track, eof, byte_done, push, pop;

  always_comb begin
    crc_n = crc;
    for (int i = 0; i < 2; i++)
      crc_n = (crc_n >> 1) ^ ((crc_n[0] ^ in[i]) ? POLY : 32'h0);
    byte_in   = {in, shreg};
    // a filter reject keeps checking the frame; a length drop stops looking at it
    track     = (state == BODY) || (state == DROP && !len_err);
    eof       = (state == BODY || state == DROP) && !inclk;
    byte_done = track && inclk && (dcnt == 2'd3);
    push      = byte_done && (state == BODY) && (bcnt != MAXL);
    pop       = emit_en && (depth > 4'd4);
    q_n       = q;
    depth_n   = depth;
    if (pop) begin
      q_n     = {8'h00, q[7:1]};
      depth_n = depth - 4'd1;
    end
    if (push) begin
      q_n[depth_n[2:0]] = byte_in;
      depth_n           = depth_n + 4'd1;
    end
    if (eof) depth_n = 4'd0;
  end

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] dst;
  logic        mac_hit;
  assign dst     = {byte_in, q[4], q[3], q[2], q[1], q[0]};
  assign mac_hit = (dst == my_mac) || (dst == 48'hffff_ffff_ffff);
`else
  logic unused_mac;
  assign unused_mac = ^my_mac;
  assign emit_en    = 1'b1;
  assign mac_rej    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      crc      <= '1;
      dcnt     <= '0;
      shreg    <= '0;
      bcnt     <= '0;
      q        <= '0;
      depth    <= '0;
      len_err  <= 1'b0;
      outclk   <= 1'b0;
      out      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      filtered <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
      emit_en  <= 1'b0;
      mac_rej  <= 1'b0;
`endif
    end else begin
      outclk   <= pop;
      if (pop) out <= q[0];
      q        <= q_n;
      depth    <= depth_n;
      done     <= eof;
      err      <= eof && ((dcnt != 2'd0) || (bcnt < MINL) || (crc != RESIDUE) || len_err);
      filtered <= eof && mac_rej;
      if (track && inclk) begin
        crc   <= crc_n;
        dcnt  <= dcnt + 2'd1;
        shreg <= {in, shreg[5:2]};
      end
      if (byte_done) bcnt <= bcnt + 11'd1;
      case (state)
        IDLE:
          if (inclk && in == 2'b01) begin
            state <= PREAMBLE;
            pcnt  <= PW'(1);
          end
        PREAMBLE:
          if (!inclk) state <= IDLE;
          else if (in == 2'b01) begin
            if (pcnt < PMIN) pcnt <= pcnt + PW'(1);
          end else if (in == 2'b11 && pcnt >= PMIN) begin
            state   <= BODY;
            crc     <= '1;
            dcnt    <= '0;
            bcnt    <= '0;
            len_err <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
            emit_en <= 1'b0;
            mac_rej <= 1'b0;
`endif
          end else state <= IDLE;
        default: // BODY, DROP
          if (!inclk) state <= IDLE;
          else if (byte_done && bcnt == MAXL) begin
            state   <= DROP;
            len_err <= 1'b1;
          end
`ifdef ETH_RX_MAC_FILTER_EN
          else if (push && bcnt == 11'd5) begin
            if (mac_hit) emit_en <= 1'b1;
            else begin
              state   <= DROP;
              mac_rej <= 1'b1;
            end
          end
`endif
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Directed bench for eth_rx_frame_check: expected bytes/status queued at drive time, checked as the DUT emits.
module tb_eth_rx_frame_check;
  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inclk = 1'b0;
  logic [1:0]  in = 2'b00;
  logic [47:0] my_mac = 48'h02_00_00_00_00_02;
  logic        outclk, done, err, filtered;
  logic [7:0]  out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_stat[$];
  logic [7:0] frame[$];

  eth_rx_frame_check dut (
    .clk(clk), .rst_n(rst_n), .inclk(inclk), .in(in), .my_mac(my_mac),
    .outclk(outclk), .out(out), .done(done), .err(err), .filtered(filtered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (outclk !== 1'b0) begin
      if (exp_bytes.size() == 0) check("unexpected outclk", {31'd0, outclk}, 32'd0);
      else check("out byte", {24'd0, out}, {24'd0, exp_bytes.pop_front()});
    end
    if (done !== 1'b0) begin
      if (exp_stat.size() == 0) check("unexpected done", {31'd0, done}, 32'd0);
      else check("err/filtered", {30'd0, err, filtered}, {30'd0, exp_stat.pop_front()});
    end
  end

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c >> 1) ^ ((c[0] ^ frame[i][b]) ? 32'hedb88320 : 32'h0);
    return ~c;
  endfunction

  task automatic build(input int len, input logic [47:0] dst);
    logic [31:0] f;
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(dst[8*i+:8]);
    for (int i = 6; i < len - 4; i++) frame.push_back(8'($urandom_range(0, 255)));
    f = crc32(len - 4);
    for (int i = 0; i < 4; i++) frame.push_back(f[8*i+:8]);
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    @(posedge clk);
    #1;
    inclk = v;
    in    = d;
  endtask

  task automatic settle();
    for (int i = 0; i < 8 && (exp_bytes.size() != 0 || exp_stat.size() != 0); i++) @(negedge clk);
    check("leftover bytes", exp_bytes.size(), 32'd0);
    check("leftover done", exp_stat.size(), 32'd0);
    exp_bytes.delete();
    exp_stat.delete();
  endtask

  task automatic send_body(input int ndib);
    logic [7:0] b;
    for (int i = 0; i < ndib; i++) begin
      b = frame[i/4];
      drive(1'b1, b[2*(i%4)+:2]);
    end
  endtask

  // ndib body dibits taken from frame; emit=0 when the whole frame is expected to be filtered
  task automatic send(input int npre, input int ndib, input bit emit, input bit filt);
    int nb, ne;
    logic [31:0] fcs;
    bit e;
    nb = ndib / 4;
    ne = (nb > MAXL ? MAXL : nb) - 4;
    if (emit) for (int i = 0; i < ne; i++) exp_bytes.push_back(frame[i]);
    fcs = {frame[nb-1], frame[nb-2], frame[nb-3], frame[nb-4]};
    e = (ndib % 4 != 0) || nb < MINL || nb > MAXL || crc32(nb - 4) != fcs;
    exp_stat.push_back({e, filt});
    repeat (npre) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    send_body(ndib);
    repeat (4) drive(1'b0, 2'b00);
    settle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset outclk", {31'd0, outclk}, 32'd0);
    check("reset out", {24'd0, out}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset filtered", {31'd0, filtered}, 32'd0);
    rst_n = 1'b1;

    build(64, my_mac);   send(28, 256, 1'b1, 1'b0);       // good minimum frame
    build(64, my_mac);   frame[20] ^= 8'h04;
                         send(28, 256, 1'b1, 1'b0);       // payload bit error
    build(64, my_mac);   send(28, 255, 1'b1, 1'b0);       // one dibit short
    build(40, my_mac);   send(28, 160, 1'b1, 1'b0);       // runt, valid FCS
    build(63, my_mac);   send(28, 252, 1'b1, 1'b0);       // one byte under minimum

    // short preamble: the following body must be ignored entirely
    repeat (3) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    repeat (16) drive(1'b1, 2'b00);
    repeat (4) drive(1'b0, 2'b00);
    settle();
    build(64, my_mac);   send(4, 256, 1'b1, 1'b0);        // minimum accepted preamble

    build(64, 48'h01_00_00_00_00_02);
`ifdef ETH_RX_MAC_FILTER_EN
    send(28, 256, 1'b0, 1'b1);
`else
    send(28, 256, 1'b1, 1'b0);
`endif
    build(64, 48'hff_ff_ff_ff_ff_ff); send(28, 256, 1'b1, 1'b0);

    build(1518, my_mac); send(28, 1518*4, 1'b1, 1'b0);    // maximum length
    build(1522, my_mac); send(28, 1522*4, 1'b1, 1'b0);    // oversize

    // reset mid-body: bytes 0..15 are out before reset, nothing after
    build(64, my_mac);
    for (int i = 0; i < 16; i++) exp_bytes.push_back(frame[i]);
    repeat (28) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    send_body(82);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    inclk = 1'b0;
    in    = 2'b00;
    #1;
    check("midreset outclk", {31'd0, outclk}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset err", {31'd0, err}, 32'd0);
    check("midreset out", {24'd0, out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    build(64, my_mac);   send(28, 256, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
